// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: packed per-requester request fields plus
// the grant / read-return signals shared back to the requesters.
interface mem_arbiter_if #(
  parameter int REG_SIZE = 8,
  parameter int NUM_REQ  = 3
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          lock;
  logic [NUM_REQ-1:0]          we;
  logic [NUM_REQ*REG_SIZE-1:0] addr;
  logic [NUM_REQ*REG_SIZE-1:0] wdata;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          rvalid;
  logic [REG_SIZE-1:0]         rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters, with short locks.
// Optional macro MEM_ARB_CU_PRIO_EN: requester 0 (control unit) wins every arbitration it joins.
module mem_arbiter #(
  parameter int REG_SIZE = 8,
  parameter int NUM_REQ  = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus,
  output logic [REG_SIZE-1:0] ram_addr,
  output logic                ram_we,
  inout  wire  [REG_SIZE-1:0] ram_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [REG_SIZE-1:0] rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;

  logic [REG_SIZE-1:0] addr_arr  [NUM_REQ];
  logic [REG_SIZE-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*REG_SIZE +: REG_SIZE];
      assign wdata_arr[gi] = bus.wdata[gi*REG_SIZE +: REG_SIZE];
    end
  endgenerate

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  logic [IDX_W-1:0] rr_winner;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_found;

  always_comb begin
    rr_winner  = rr_ptr_q;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!scan_found && bus.req[scan_idx]) begin
        rr_winner  = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  logic [IDX_W-1:0] winner;
`ifdef MEM_ARB_CU_PRIO_EN
  // With req[0] clear the rotating scan can only land on 1..NUM_REQ-1.
  assign winner = bus.req[0] ? '0 : rr_winner;
`else
  assign winner = rr_winner;
`endif

  logic                owner_req;
  logic                owner_we;
  logic                owner_lock;
  logic [REG_SIZE-1:0] owner_addr;
  logic [REG_SIZE-1:0] owner_wdata;
  logic [IDX_W-1:0]    owner_next;

  assign owner_req   = bus.req[owner_q];
  assign owner_we    = bus.we[owner_q];
  assign owner_lock  = bus.lock[owner_q];
  assign owner_addr  = addr_arr[owner_q];
  assign owner_wdata = wdata_arr[owner_q];
  assign owner_next  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  logic [NUM_REQ-1:0]  gnt_c;
  logic                ram_we_c;
  logic [REG_SIZE-1:0] ram_addr_c;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    gnt_c      = '0;
    ram_we_c   = 1'b0;
    ram_addr_c = '0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d    = winner;
          lock_cnt_d = '0;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        // A request dropped before its grant is a withdrawal: no RAM cycle at all.
        if (owner_req) begin
          gnt_c[owner_q] = 1'b1;
          ram_addr_c     = owner_addr;
          ram_we_c       = owner_we;
          if (!owner_we) begin
            rdata_d           = ram_data;
            rvalid_d[owner_q] = 1'b1;
          end
        end
        if (owner_req && owner_lock && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset must silence the RAM immediately, not one cycle later.
    if (rst) begin
      gnt_c      = '0;
      ram_we_c   = 1'b0;
      ram_addr_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign ram_addr   = ram_addr_c;
  assign ram_we     = ram_we_c;
  assign ram_data   = ram_we_c ? owner_wdata : {REG_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, lock/reset sequences, then random traffic
// checked against a transaction-level reference model with its own RAM image.
module tb_mem_arbiter;
  localparam int RS    = 8;
  localparam int N     = 3;
  localparam int ML    = 4;
  localparam int BOUND = (N - 1) * (ML + 1) + 1;
`ifdef MEM_ARB_CU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.REG_SIZE(RS), .NUM_REQ(N)) bus ();
  wire [RS-1:0] ram_addr;
  wire          ram_we;
  wire [RS-1:0] ram_data;

  mem_arbiter #(.REG_SIZE(RS), .NUM_REQ(N), .MAX_LOCK(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_data (ram_data)
  );

  // Bench-side RAM: drives the bus whenever the arbiter is not writing.
  logic [RS-1:0] mem [256];
  logic          preset_en = 1'b0;
  logic [RS-1:0] preset_addr = '0;
  logic [RS-1:0] preset_val = '0;
  assign ram_data = ram_we ? {RS{1'bz}} : mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else if (preset_en) mem[preset_addr] <= preset_val;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic preset(input logic [RS-1:0] a, input logic [RS-1:0] v);
    preset_addr = a;
    preset_val  = v;
    preset_en   = 1'b1;
    @(posedge clk);
    #1 preset_en = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0]    req, lock, we;
    logic [N*RS-1:0] addr, wdata;
    logic [N-1:0]    e_gnt;
    logic            e_we;
    logic [RS-1:0]   e_addr, e_data;
    logic [N-1:0]    e_rvalid;
    logic [RS-1:0]   e_rdata;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N*RS-1:0] a,
                              input logic [N*RS-1:0] d, input logic [N-1:0] g, input logic ew,
                              input logic [RS-1:0] ea, input logic [RS-1:0] ed,
                              input logic [N-1:0] rv, input logic [RS-1:0] rd);
    vec_t v;
    v.req = r; v.lock = '0; v.we = w; v.addr = a; v.wdata = d;
    v.e_gnt = g; v.e_we = ew; v.e_addr = ea; v.e_data = ed; v.e_rvalid = rv; v.e_rdata = rd;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [RS-1:0] ref_mem [256];
  int            m_cur, m_burst, m_ptr;
  logic [RS-1:0] m_rdata;
  logic [N-1:0]  m_rvalid;
  int            waitc [N];
  logic [N-1:0]  e_gnt;
  logic          e_we;
  logic [RS-1:0] e_addr, e_data;

  function automatic int pick(input logic [N-1:0] r);
    if (PRIO && r[0]) return 0;
    for (int k = 0; k < N; k++)
      if (bitof(r, (m_ptr + k) % N)) return (m_ptr + k) % N;
    return 0;
  endfunction

  task automatic model_cycle();
    logic [N-1:0] nv;
    int w;
    e_gnt = '0; e_we = 1'b0; e_addr = '0; e_data = '0;
    if (m_cur >= 0 && bitof(bus.req, m_cur)) begin
      e_gnt  = N'(1) << m_cur;
      e_we   = bitof(bus.we, m_cur);
      e_addr = RS'(bus.addr >> (m_cur * RS));
      e_data = RS'(bus.wdata >> (m_cur * RS));
    end
    chk("rnd_gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("rnd_ram_we", 32'(ram_we), 32'(e_we));
    chk("rnd_ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("rnd_rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    chk("rnd_rdata", 32'(bus.rdata), 32'(m_rdata));
    if (e_we) chk("rnd_ram_data", 32'(ram_data), 32'(e_data));
    // advance the model across the coming clock edge
    nv = '0;
    if (m_cur < 0) begin
      if (|bus.req) begin
        w = pick(bus.req);
        if (!PRIO) chk("rnd_starve", 32'(waitc[w] + 1 <= BOUND), 32'd1);
        for (int i = 0; i < N; i++) if (bitof(bus.req, i) && i != w) waitc[i]++;
        waitc[w] = 0;
        m_cur = w;
        m_burst = 1;
      end
    end else begin
      if (bitof(bus.req, m_cur)) begin
        if (!e_we) begin
          m_rdata = ref_mem[e_addr];
          nv = N'(1) << m_cur;
        end else begin
          ref_mem[e_addr] = e_data;
        end
      end
      if (bitof(bus.req, m_cur) && bitof(bus.lock, m_cur) && m_burst < ML) begin
        m_burst++;
      end else begin
        m_ptr = (m_cur + 1) % N;
        m_cur = -1;
      end
    end
    m_rvalid = nv;
  endtask

  // ---------------- random requester agents ----------------
  bit            act [N];
  logic [RS-1:0] a_addr [N];
  logic [RS-1:0] a_data [N];
  bit            a_we [N];
  bit            a_lock [N];

  task automatic new_fields(input int i);
    a_we[i]   = $urandom_range(0, 1) == 1;
    a_addr[i] = RS'($urandom_range(0, 15));
    a_data[i] = RS'($urandom_range(0, 255));
  endtask

  task automatic drive_agents();
    logic [N-1:0] r, l, w;
    logic [N*RS-1:0] a, d;
    r = '0; l = '0; w = '0; a = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (e_gnt[i]) begin
        act[i] = $urandom_range(0, 9) < 6;
        if (act[i]) new_fields(i);
      end else if (act[i] && $urandom_range(0, 99) < 3) begin
        act[i] = 1'b0;
      end else if (!act[i] && $urandom_range(0, 9) < 3) begin
        act[i] = 1'b1;
        new_fields(i);
      end
      if (!act[i]) waitc[i] = 0;
      a_lock[i] = $urandom_range(0, 1) == 1;
      r |= N'(act[i]) << i;
      l |= N'(act[i] && a_lock[i]) << i;
      w |= N'(a_we[i]) << i;
      a |= (N*RS)'(a_addr[i]) << (i * RS);
      d |= (N*RS)'(a_data[i]) << (i * RS);
    end
    bus.req = r; bus.lock = l; bus.we = w; bus.addr = a; bus.wdata = d;
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0]    exp_lock [12];
  logic [N*RS-1:0] c_addr, c_data, rd_addr;
  int              k2;
  bit              r0_done;

  initial begin
    clear_inputs();
    c_addr  = {8'h42, 8'h41, 8'h40};
    c_data  = {8'h33, 8'h22, 8'h11};
    rd_addr = {8'h00, 8'h10, 8'h00};
    tbl[0]  = mk(3'b111, 3'b111, c_addr, c_data, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'h00);
    tbl[1]  = mk(3'b111, 3'b111, c_addr, c_data, 3'b001, 1, 8'h40, 8'h11, 3'b000, 8'h00);
    tbl[2]  = mk(3'b111, 3'b111, c_addr, c_data, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'h00);
    tbl[3]  = PRIO ? mk(3'b111, 3'b111, c_addr, c_data, 3'b001, 1, 8'h40, 8'h11, 3'b000, 8'h00)
                   : mk(3'b111, 3'b111, c_addr, c_data, 3'b010, 1, 8'h41, 8'h22, 3'b000, 8'h00);
    tbl[4]  = mk(3'b111, 3'b111, c_addr, c_data, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'h00);
    tbl[5]  = PRIO ? mk(3'b111, 3'b111, c_addr, c_data, 3'b001, 1, 8'h40, 8'h11, 3'b000, 8'h00)
                   : mk(3'b111, 3'b111, c_addr, c_data, 3'b100, 1, 8'h42, 8'h33, 3'b000, 8'h00);
    tbl[6]  = mk(3'b111, 3'b111, c_addr, c_data, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'h00);
    tbl[7]  = mk(3'b111, 3'b111, c_addr, c_data, 3'b001, 1, 8'h40, 8'h11, 3'b000, 8'h00);
    tbl[8]  = mk(3'b010, 3'b000, rd_addr, '0, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'h00);
    tbl[9]  = mk(3'b010, 3'b000, rd_addr, '0, 3'b010, 0, 8'h10, 8'h00, 3'b000, 8'h00);
    tbl[10] = mk(3'b000, 3'b000, rd_addr, '0, 3'b000, 0, 8'h00, 8'h00, 3'b010, 8'hA5);
    tbl[11] = mk(3'b010, 3'b000, rd_addr, '0, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'hA5);
    tbl[12] = mk(3'b000, 3'b000, rd_addr, '0, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'hA5);
    tbl[13] = mk(3'b111, 3'b111, c_addr, c_data, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'hA5);
    tbl[14] = PRIO ? mk(3'b111, 3'b111, c_addr, c_data, 3'b001, 1, 8'h40, 8'h11, 3'b000, 8'hA5)
                   : mk(3'b111, 3'b111, c_addr, c_data, 3'b100, 1, 8'h42, 8'h33, 3'b000, 8'hA5);
    tbl[15] = mk(3'b000, 3'b000, c_addr, c_data, 3'b000, 0, 8'h00, 8'h00, 3'b000, 8'hA5);
    exp_lock = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                 3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};

    // reset: outputs forced quiet even with every requester asking
    rst = 1'b1;
    preset(8'h10, 8'hA5);
    preset(8'h30, 8'h99);
    bus.req = 3'b111; bus.we = 3'b111; bus.addr = c_addr; bus.wdata = c_data;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);

    // contention, single read, withdrawal
    for (int r = 0; r < 16; r++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req = tbl[r].req; bus.lock = tbl[r].lock; bus.we = tbl[r].we;
      bus.addr = tbl[r].addr; bus.wdata = tbl[r].wdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", r), 32'(bus.gnt), 32'(tbl[r].e_gnt));
      chk($sformatf("tbl%0d_ram_we", r), 32'(ram_we), 32'(tbl[r].e_we));
      chk($sformatf("tbl%0d_ram_addr", r), 32'(ram_addr), 32'(tbl[r].e_addr));
      chk($sformatf("tbl%0d_rvalid", r), 32'(bus.rvalid), 32'(tbl[r].e_rvalid));
      chk($sformatf("tbl%0d_rdata", r), 32'(bus.rdata), 32'(tbl[r].e_rdata));
      if (tbl[r].e_we) chk($sformatf("tbl%0d_ram_data", r), 32'(ram_data), 32'(tbl[r].e_data));
    end
    chk("tbl_mem40", 32'(mem[8'h40]), 32'h11);

    // lock burst with requester 0 joining mid-burst
    @(posedge clk);
    #1 rst = 1'b1; clear_inputs();
    @(posedge clk);
    k2 = 0; r0_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 rst = 1'b0;
      bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
      if (k2 < 6) begin
        bus.req[2] = 1'b1; bus.lock[2] = 1'b1; bus.we[2] = 1'b1;
        bus.addr[2*RS +: RS] = RS'(8'h20 + k2);
        bus.wdata[2*RS +: RS] = RS'(k2 + 1);
      end
      if (c >= 2 && !r0_done) begin
        bus.req[0] = 1'b1; bus.we[0] = 1'b1;
        bus.addr[0 +: RS] = 8'h50; bus.wdata[0 +: RS] = 8'h77;
      end
      @(negedge clk);
      chk($sformatf("lock_c%0d_gnt", c), 32'(bus.gnt), 32'(exp_lock[c]));
      if (exp_lock[c][2]) chk($sformatf("lock_c%0d_addr", c), 32'(ram_addr), 32'(8'h20 + k2));
      if (exp_lock[c][0]) chk($sformatf("lock_c%0d_addr", c), 32'(ram_addr), 32'h50);
      if (exp_lock[c][2]) k2++;
      if (exp_lock[c][0]) r0_done = 1'b1;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("lock_mem%0h", 8'h20 + i), 32'(mem[8'h20 + i]), 32'(i + 1));
    chk("lock_mem50", 32'(mem[8'h50]), 32'h77);

    // reset in the middle of a write
    @(posedge clk);
    #1 clear_inputs();
    bus.req[1] = 1'b1; bus.we[1] = 1'b1; bus.addr[RS +: RS] = 8'h30; bus.wdata[RS +: RS] = 8'h5C;
    @(negedge clk);
    chk("mrst_idle_gnt", 32'(bus.gnt), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_ram_we", 32'(ram_we), 0);
    chk("mrst_gnt", 32'(bus.gnt), 0);
    chk("mrst_ram_addr", 32'(ram_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0; clear_inputs();
    @(negedge clk);
    chk("mrst_after_gnt", 32'(bus.gnt), 0);
    chk("mrst_after_rvalid", 32'(bus.rvalid), 0);
    chk("mrst_after_rdata", 32'(bus.rdata), 0);
    chk("mrst_mem30", 32'(mem[8'h30]), 32'h99);
    @(posedge clk);
    #1 bus.req[1] = 1'b1; bus.addr[RS +: RS] = 8'h30;
    @(negedge clk);
    chk("mrst_rd_idle", 32'(bus.gnt), 0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_rd_gnt", 32'(bus.gnt), 32'b010);
    chk("mrst_rd_addr", 32'(ram_addr), 32'h30);
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    chk("mrst_rd_rvalid", 32'(bus.rvalid), 32'b010);
    chk("mrst_rd_rdata", 32'(bus.rdata), 32'h99);

    // randomized traffic against the reference model
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m_cur = -1; m_burst = 0; m_ptr = 0; m_rdata = '0; m_rvalid = '0; e_gnt = '0;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; waitc[i] = 0; a_we[i] = 1'b0; a_addr[i] = '0; a_data[i] = '0; a_lock[i] = 1'b0;
    end
    drive_agents();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1 drive_agents();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data RAM between NUM_REQ requesters: control unit, program loader and debug port.
- Round-robin arbitration with an optional short lock for back-to-back accesses.
- Sits between the requesters and the RAM, and owns the tri-state RAM data bus.
- Requester 0 is the control unit by convention.

Parameters:
- REG_SIZE, 8, width of RAM address and data.
- NUM_REQ, 3, number of requesters (2..8).
- MAX_LOCK, 4, maximum consecutive accesses one requester may hold under lock (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester access request.
- lock  in  NUM_REQ  per-requester request to keep the grant after the current access.
- we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- addr  in  NUM_REQ*REG_SIZE  packed addresses; requester i uses slice [i*REG_SIZE +: REG_SIZE].
- wdata  in  NUM_REQ*REG_SIZE  packed write data, same slicing.
- gnt  out  NUM_REQ  one-hot; high in the cycle the access is performed.
- rvalid  out  NUM_REQ  one-hot pulse; rdata is valid for that requester.
- rdata  out  REG_SIZE  registered read data, shared by all requesters.
- ram_addr  out  REG_SIZE  RAM address.
- ram_we  out  1  RAM write enable.
- ram_data  inout  REG_SIZE  RAM data bus; driven with wdata when ram_we=1, else Z.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr_ptr=0; owner=0; lock_cnt=0; rdata=0; rvalid=0.
  - While rst=1, gnt=0, ram_we=0, ram_addr=0 and ram_data=Z, forced combinationally.
  - Reset mid-access aborts the access with no write.
- Requester rule: hold req/we/addr/wdata stable from assertion until gnt is seen. A request dropped before gnt is treated as withdrawn.
- State IDLE:
  - gnt=0, ram_we=0, ram_addr=0.
  - If any req: owner = first set req bit searching from rr_ptr upward, wrapping modulo NUM_REQ; lock_cnt=0; go to ACCESS.
  - Else stay in IDLE.
- State ACCESS:
  - If req[owner]=1: gnt[owner]=1; ram_addr=addr[owner]; ram_we=we[owner]; ram_data=wdata[owner] when writing.
  - On a read, ram_data is sampled at the clock edge into rdata, and rvalid[owner]=1 in the next cycle only.
  - If req[owner]=0 (withdrawn): no access, gnt=0.
  - Next state: if req[owner] & lock[owner] & (lock_cnt < MAX_LOCK-1), stay in ACCESS with lock_cnt+1.
  - Otherwise go to IDLE with rr_ptr = owner+1, wrapping to 0 at NUM_REQ.
- Latency and throughput:
  - req seen in IDLE at cycle 0 -> gnt at cycle 1 -> rvalid at cycle 2.
  - Unlocked: 1 access per 2 cycles. Locked: 1 access per cycle, for up to MAX_LOCK accesses.
- rdata holds its last read value until the next read; writes never change rdata or rvalid.
- Simultaneous requests: exactly one winner per arbitration. Losers keep req high and are served in later rounds.
- Starvation bound: any continuously asserted req is granted within (NUM_REQ-1)*(MAX_LOCK+1)+1 arbitrations.
- lock is ignored in IDLE. lock without req has no effect.
- gnt and rvalid are always one-hot or zero.

Optional Feature:
- Macro: MEM_ARB_CU_PRIO_EN.
- Defined: requester 0 (control unit) wins every IDLE arbitration in which req[0]=1, regardless of rr_ptr. Requesters 1..NUM_REQ-1 round-robin among themselves. A lock held by another requester is still honoured up to MAX_LOCK.
- Undefined: pure round-robin across all requesters, as above.

Test Plan:
- Single read: RAM[0x10]=0xA5, req[1]=1, we=0, addr=0x10 -> gnt[1] at cycle 1, rvalid[1] at cycle 2, rdata=0xA5; ram_we stays 0.
- Contention: req=3'b111 held continuously with writes -> grant order 0,1,2,0 (rr_ptr=0 after reset); with MEM_ARB_CU_PRIO_EN, order 0,0,0,...
- Lock: MAX_LOCK=4, req[2]=lock[2]=1 held, writes 0x01..0x06 to 0x20..0x25 -> 4 consecutive gnt[2] cycles covering 0x20..0x23; then IDLE; then a new lock burst covers 0x24..0x25.
- Lock preemption: during the above, req[0]=1 -> req[0] granted in the arbitration right after the 4-cycle burst, before requester 2 resumes.
- Withdrawal: req[1] asserted in IDLE then deasserted in ACCESS -> gnt=0, ram_we=0, no rvalid; return to IDLE; rr_ptr=2.
- Reset mid-write: rst=1 during an ACCESS write to 0x30 -> ram_we=0 that cycle; RAM[0x30] unchanged; after reset, state IDLE and all outputs at reset values.
